// File: rtl/counter_read_port_if.sv
// Bus-side signal bundle between the decoder/counter core and one counter's read-back port.
// The master side drives commands, reads and live core status; the slave side returns read data.
interface counter_read_port_if;
    logic        ctrl_wr;
    logic [5:0]  ctrl_word;
    logic        rb_cmd;
    logic        rb_latch_count;
    logic        rb_latch_status;
    logic        rd;
    logic [15:0] count_in;
    logic        out_in;
    logic        null_count_in;
    logic [7:0]  data_out;
    logic        rd_ack;

    modport master (
        output ctrl_wr, ctrl_word, rb_cmd, rb_latch_count, rb_latch_status,
        output rd, count_in, out_in, null_count_in,
        input  data_out, rd_ack
    );

    modport slave (
        input  ctrl_wr, ctrl_word, rb_cmd, rb_latch_count, rb_latch_status,
        input  rd, count_in, out_in, null_count_in,
        output data_out, rd_ack
    );
endinterface

// File: rtl/counter_read_port.sv
// 8254 counter read-back path: RW-mode flip-flop, count latch and status latch.
// Returns the count or status to the CPU one byte per read strobe.
module counter_read_port (
    input  logic                 clk,
    input  logic                 rst,
    counter_read_port_if.slave   bus
);

    localparam logic [1:0] RW_LATCH = 2'b00;
    localparam logic [1:0] RW_LSB   = 2'b01;
    localparam logic [1:0] RW_MSB   = 2'b10;
    localparam logic [1:0] RW_BOTH  = 2'b11;

    logic [1:0]  rw_mode_q,   rw_mode_d;
    logic [2:0]  mode_q,      mode_d;
    logic        bcd_q,       bcd_d;
    logic [15:0] cnt_latch_q, cnt_latch_d;
    logic        cnt_held_q,  cnt_held_d;
    logic [7:0]  sts_latch_q, sts_latch_d;
    logic        sts_held_q,  sts_held_d;
    logic        byte_ptr_q,  byte_ptr_d;
    logic [7:0]  data_out_q,  data_out_d;
    logic        rd_ack_q,    rd_ack_d;

    logic [15:0] src_s;
    logic        cnt_free_s;
    logic        sts_free_s;

    // Next-state: control word wins over a same-cycle read; a read-back sees latches freed by a same-cycle read.
    always_comb begin
        rw_mode_d   = rw_mode_q;
        mode_d      = mode_q;
        bcd_d       = bcd_q;
        cnt_latch_d = cnt_latch_q;
        cnt_held_d  = cnt_held_q;
        sts_latch_d = sts_latch_q;
        sts_held_d  = sts_held_q;
        byte_ptr_d  = byte_ptr_q;
        data_out_d  = data_out_q;
        rd_ack_d    = 1'b0;
        src_s       = cnt_held_q ? cnt_latch_q : bus.count_in;
        cnt_free_s  = ~cnt_held_q;
        sts_free_s  = ~sts_held_q;

        if (bus.ctrl_wr) begin
            if (bus.ctrl_word[5:4] != RW_LATCH) begin
                rw_mode_d  = bus.ctrl_word[5:4];
                mode_d     = bus.ctrl_word[3:1];
                bcd_d      = bus.ctrl_word[0];
                cnt_held_d = 1'b0;
                sts_held_d = 1'b0;
                byte_ptr_d = 1'b0;
            end else if (cnt_free_s) begin
                cnt_latch_d = bus.count_in;
                cnt_held_d  = 1'b1;
            end else begin
                cnt_held_d = cnt_held_q;
            end
        end else begin
            if (bus.rd) begin
                rd_ack_d = 1'b1;
                if (sts_held_q) begin
                    data_out_d = sts_latch_q;
                    sts_held_d = 1'b0;
                    sts_free_s = 1'b1;
                end else begin
                    case (rw_mode_q)
                        RW_LSB: begin
                            data_out_d = src_s[7:0];
                            cnt_held_d = 1'b0;
                            cnt_free_s = 1'b1;
                        end
                        RW_MSB: begin
                            data_out_d = src_s[15:8];
                            cnt_held_d = 1'b0;
                            cnt_free_s = 1'b1;
                        end
                        RW_BOTH: begin
                            if (byte_ptr_q) begin
                                data_out_d = src_s[15:8];
                                cnt_held_d = 1'b0;
                                cnt_free_s = 1'b1;
                            end else begin
                                data_out_d = src_s[7:0];
                            end
                            byte_ptr_d = ~byte_ptr_q;
                        end
                        default: begin
                            data_out_d = src_s[7:0];
                        end
                    endcase
                end
            end else begin
                rd_ack_d = 1'b0;
            end

            if (bus.rb_cmd) begin
                if (bus.rb_latch_count && cnt_free_s) begin
                    cnt_latch_d = bus.count_in;
                    cnt_held_d  = 1'b1;
                end else begin
                    cnt_latch_d = cnt_latch_d;
                end
                if (bus.rb_latch_status && sts_free_s) begin
                    sts_latch_d = {bus.out_in, bus.null_count_in, rw_mode_q, mode_q, bcd_q};
                    sts_held_d  = 1'b1;
                end else begin
                    sts_latch_d = sts_latch_d;
                end
            end else begin
                sts_latch_d = sts_latch_q;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rw_mode_q   <= RW_BOTH;
            mode_q      <= 3'b000;
            bcd_q       <= 1'b0;
            cnt_latch_q <= 16'h0000;
            cnt_held_q  <= 1'b0;
            sts_latch_q <= 8'h00;
            sts_held_q  <= 1'b0;
            byte_ptr_q  <= 1'b0;
            data_out_q  <= 8'h00;
            rd_ack_q    <= 1'b0;
        end else begin
            rw_mode_q   <= rw_mode_d;
            mode_q      <= mode_d;
            bcd_q       <= bcd_d;
            cnt_latch_q <= cnt_latch_d;
            cnt_held_q  <= cnt_held_d;
            sts_latch_q <= sts_latch_d;
            sts_held_q  <= sts_held_d;
            byte_ptr_q  <= byte_ptr_d;
            data_out_q  <= data_out_d;
            rd_ack_q    <= rd_ack_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_ack   = rd_ack_q;

endmodule

// File: tb/tb_counter_read_port.sv
// Directed bench for counter_read_port: hand-computed bytes checked after each read strobe.
module tb_counter_read_port;
    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    counter_read_port_if bus ();

    counter_read_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total = n_total + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ctrl(input logic [5:0] w);
        @(negedge clk);
        bus.ctrl_wr   = 1'b1;
        bus.ctrl_word = w;
        @(negedge clk);
        bus.ctrl_wr   = 1'b0;
    endtask

    task automatic rb(input logic lc, input logic ls);
        @(negedge clk);
        bus.rb_cmd          = 1'b1;
        bus.rb_latch_count  = lc;
        bus.rb_latch_status = ls;
        @(negedge clk);
        bus.rb_cmd          = 1'b0;
        bus.rb_latch_count  = 1'b0;
        bus.rb_latch_status = 1'b0;
    endtask

    task automatic do_rd(input string tag, input logic [7:0] exp);
        @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        check_eq({tag, "_ack"}, {15'd0, bus.rd_ack}, 16'd1);
        check_eq(tag, {8'd0, bus.data_out}, {8'd0, exp});
    endtask

    initial begin
        n_total             = 0;
        n_bad               = 0;
        rst                 = 1'b1;
        bus.ctrl_wr         = 1'b0;
        bus.ctrl_word       = 6'h00;
        bus.rb_cmd          = 1'b0;
        bus.rb_latch_count  = 1'b0;
        bus.rb_latch_status = 1'b0;
        bus.rd              = 1'b0;
        bus.count_in        = 16'h0000;
        bus.out_in          = 1'b0;
        bus.null_count_in   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_data", {8'd0, bus.data_out}, 16'h0000);
        check_eq("rst_ack", {15'd0, bus.rd_ack}, 16'd0);

        // Mode 11 live reads, ack is a single pulse
        ctrl(6'h30);
        bus.count_in = 16'h1234;
        do_rd("live_lsb", 8'h34);
        @(negedge clk);
        check_eq("ack_pulse", {15'd0, bus.rd_ack}, 16'd0);
        do_rd("live_msb", 8'h12);

        // Counter latch, back-to-back reads of the held value
        bus.count_in = 16'hABCD;
        ctrl(6'h00);
        bus.count_in = 16'h0001;
        @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        check_eq("b2b_lsb", {8'd0, bus.data_out}, 16'h00CD);
        check_eq("b2b_lsb_ack", {15'd0, bus.rd_ack}, 16'd1);
        @(negedge clk);
        bus.rd = 1'b0;
        check_eq("b2b_msb", {8'd0, bus.data_out}, 16'h00AB);
        check_eq("b2b_msb_ack", {15'd0, bus.rd_ack}, 16'd1);
        do_rd("after_latch", 8'h01);

        // Mode 01: second latch does not overwrite
        ctrl(6'h10);
        bus.count_in = 16'h1111;
        ctrl(6'h00);
        bus.count_in = 16'h2222;
        ctrl(6'h00);
        do_rd("first_latch", 8'h11);
        do_rd("m01_live", 8'h22);

        // Read-back of status and count in mode 10
        ctrl(6'h22);
        bus.count_in      = 16'h5A3C;
        bus.out_in        = 1'b1;
        bus.null_count_in = 1'b0;
        rb(1'b1, 1'b1);
        bus.count_in = 16'h0000;
        bus.out_in   = 1'b0;
        do_rd("status", 8'hA2);
        do_rd("rb_msb", 8'h5A);
        do_rd("m10_live", 8'h00);

        // Mode 11: latch taken between LSB and MSB reads
        ctrl(6'h30);
        bus.count_in = 16'h4455;
        do_rd("m11_lsb", 8'h55);
        bus.count_in = 16'h7788;
        ctrl(6'h00);
        bus.count_in = 16'h99AA;
        do_rd("mid_latch", 8'h77);
        do_rd("mid_live", 8'hAA);

        // ctrl_wr with rd: read dropped, pointer reset
        @(negedge clk);
        bus.ctrl_wr   = 1'b1;
        bus.ctrl_word = 6'h30;
        bus.rd        = 1'b1;
        @(negedge clk);
        bus.ctrl_wr = 1'b0;
        bus.rd      = 1'b0;
        check_eq("wr_rd_ack", {15'd0, bus.rd_ack}, 16'd0);
        check_eq("wr_rd_hold", {8'd0, bus.data_out}, 16'h00AA);
        bus.count_in = 16'h3456;
        do_rd("ptr_reset", 8'h56);

        // Reset discards a held latch
        ctrl(6'h30);
        bus.count_in = 16'hBEEF;
        ctrl(6'h00);
        bus.count_in = 16'hC0DE;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst2_data", {8'd0, bus.data_out}, 16'h0000);
        do_rd("rst_live", 8'hDE);

        // Read-back with rd: read releases, latch recaptured same cycle
        ctrl(6'h10);
        bus.count_in = 16'h1357;
        ctrl(6'h00);
        bus.count_in = 16'h2468;
        @(negedge clk);
        bus.rd             = 1'b1;
        bus.rb_cmd         = 1'b1;
        bus.rb_latch_count = 1'b1;
        @(negedge clk);
        bus.rd             = 1'b0;
        bus.rb_cmd         = 1'b0;
        bus.rb_latch_count = 1'b0;
        check_eq("rb_rd_old", {8'd0, bus.data_out}, 16'h0057);
        bus.count_in = 16'h0F0F;
        do_rd("rb_rd_new", 8'h68);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
